// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: 10-entry code table, one coded bit per handshake,
// one-cycle symbol pulses, run completion after a programmed symbol count.
module huffman_decoder #(
    parameter int MAX_LEN = 9,
    parameter int CNT_W   = 9
) (
    input  logic             Clk_in,
    input  logic             nRst,
    input  logic             Code_wr,
    input  logic [3:0]       Code_sym,
    input  logic [3:0]       Code_len,
    input  logic [8:0]       Code_val,
    input  logic             Start,
    input  logic [CNT_W-1:0] Sym_total,
    input  logic             Bit_in,
    input  logic             Bit_valid,
    output logic             Bit_ready,
    output logic [3:0]       Sym_out,
    output logic             Sym_valid,
    output logic [CNT_W-1:0] Sym_count,
    output logic             Fin,
    output logic             Err
);

    localparam logic [3:0] MAXL = 4'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, DECODE, DONE, ERR} state_t;

    state_t             state_q;
    logic [9:0]         tvalid_q;
    logic [3:0]         tlen_q [10];
    logic [8:0]         tval_q [10];
    logic [MAX_LEN-1:0] acc_q;
    logic [3:0]         len_q;
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   sym_count_q;
    logic [3:0]         sym_out_q;
    logic               sym_valid_q;
    logic               fin_q;
    logic               err_q;

    logic               wr_en_d;
    logic [3:0]         n_d;
    logic [MAX_LEN-1:0] acc_d;
    logic [8:0]         mask_d;
    logic [8:0]         acc_m_d;
    logic               hit_d;
    logic [3:0]         hit_sym_d;
    logic [CNT_W-1:0]   count_d;

    assign wr_en_d = (state_q == IDLE) && Code_wr && (Code_sym <= 4'd9) && (Code_len <= MAXL);

    // Descending scan so the lowest matching entry is the one left in hit_sym_d.
    always_comb begin
        n_d       = len_q + 4'd1;
        acc_d     = {acc_q[MAX_LEN-2:0], Bit_in};
        mask_d    = 9'((10'd1 << n_d) - 10'd1);
        acc_m_d   = 9'(acc_d) & mask_d;
        count_d   = sym_count_q + 1'b1;
        hit_d     = 1'b0;
        hit_sym_d = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (tvalid_q[k] && (tlen_q[k] == n_d) && ((tval_q[k] & mask_d) == acc_m_d)) begin
                hit_d     = 1'b1;
                hit_sym_d = 4'(k);
            end
        end
    end

    // Length/value are only meaningful behind a set valid bit, so they carry no reset.
    always_ff @(posedge Clk_in) begin
        if (wr_en_d) begin
            tlen_q[Code_sym] <= Code_len;
            tval_q[Code_sym] <= Code_val;
        end
    end

    always_ff @(posedge Clk_in or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            tvalid_q    <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            total_q     <= '0;
            sym_count_q <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            if (wr_en_d)
                tvalid_q[Code_sym] <= (Code_len != 4'd0);
            case (state_q)
                DECODE: begin
                    if (Bit_valid) begin
                        if (hit_d) begin
                            sym_out_q   <= hit_sym_d;
                            sym_valid_q <= 1'b1;
                            sym_count_q <= count_d;
                            acc_q       <= '0;
                            len_q       <= '0;
                            if (count_d == total_q) begin
                                fin_q   <= 1'b1;
                                state_q <= DONE;
                            end
                        end else if (n_d == MAXL) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end else begin
                            acc_q <= acc_d;
                            len_q <= n_d;
                        end
                    end
                end
                default: begin
                    if (Start) begin
                        sym_count_q <= '0;
                        acc_q       <= '0;
                        len_q       <= '0;
                        err_q       <= 1'b0;
                        total_q     <= Sym_total;
                        if (Sym_total == '0) begin
                            fin_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            fin_q   <= 1'b0;
                            state_q <= DECODE;
                        end
                    end
                end
            endcase
        end
    end

    assign Bit_ready = (state_q == DECODE);
    assign Sym_out   = sym_out_q;
    assign Sym_valid = sym_valid_q;
    assign Sym_count = sym_count_q;
    assign Fin       = fin_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: expected symbols are queued as the
// final bit of each codeword is driven and popped when Sym_valid pulses.
module tb_huffman_decoder;

    logic       Clk_in = 1'b0;
    logic       nRst = 1'b0;
    logic       Code_wr = 1'b0;
    logic [3:0] Code_sym = '0;
    logic [3:0] Code_len = '0;
    logic [8:0] Code_val = '0;
    logic       Start = 1'b0;
    logic [8:0] Sym_total = '0;
    logic       Bit_in = 1'b0;
    logic       Bit_valid = 1'b0;
    logic       Bit_ready;
    logic [3:0] Sym_out;
    logic       Sym_valid;
    logic [8:0] Sym_count;
    logic       Fin;
    logic       Err;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb_q[$];

    huffman_decoder #(.MAX_LEN(9), .CNT_W(9)) dut (
        .Clk_in(Clk_in), .nRst(nRst), .Code_wr(Code_wr), .Code_sym(Code_sym),
        .Code_len(Code_len), .Code_val(Code_val), .Start(Start), .Sym_total(Sym_total),
        .Bit_in(Bit_in), .Bit_valid(Bit_valid), .Bit_ready(Bit_ready), .Sym_out(Sym_out),
        .Sym_valid(Sym_valid), .Sym_count(Sym_count), .Fin(Fin), .Err(Err)
    );

    always #5 Clk_in = ~Clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge Clk_in) begin
        if (Sym_valid === 1'b1) begin
            if (sb_q.size() == 0)
                chk("sym_unexpected", 32'(Sym_out), 32'hFFFF);
            else
                chk("sym", 32'(Sym_out), 32'(sb_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic write_code(input logic [3:0] sym, input logic [3:0] len, input logic [8:0] val);
        Code_wr = 1'b1; Code_sym = sym; Code_len = len; Code_val = val;
        tick();
        Code_wr = 1'b0;
    endtask

    // A coded 0 is presented alongside Start; it must not be consumed.
    task automatic do_start(input logic [8:0] total);
        Start = 1'b1; Sym_total = total; Bit_valid = 1'b1; Bit_in = 1'b0;
        tick();
        Start = 1'b0; Bit_valid = 1'b0;
        chk("start_ready", 32'(Bit_ready), 32'(total != 0));
        chk("start_fin", 32'(Fin), 32'(total == 0));
        chk("start_err", 32'(Err), 0);
        chk("start_count", 32'(Sym_count), 0);
    endtask

    task automatic send_bit(input logic b);
        Bit_in = b; Bit_valid = 1'b1;
        tick();
        Bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] sym, input int len, input logic [8:0] val, input int gap);
        for (int i = len - 1; i >= 0; i--) begin
            if (i == 0) sb_q.push_back(sym);
            send_bit(val[i]);
            if (i == 0) chk("pulse", 32'(Sym_valid), 1);
            for (int g = 0; g < gap; g++) begin
                tick();
                if (i == 0 && g == 0) chk("pulse_width", 32'(Sym_valid), 0);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(Bit_ready), 0);
        chk({tag, "_out"}, 32'(Sym_out), 0);
        chk({tag, "_valid"}, 32'(Sym_valid), 0);
        chk({tag, "_count"}, 32'(Sym_count), 0);
        chk({tag, "_fin"}, 32'(Fin), 0);
        chk({tag, "_err"}, 32'(Err), 0);
    endtask

    task automatic pulse_reset();
        #3 nRst = 1'b0;
        #1;
        check_idle_outputs("rst");
        tick();
        nRst = 1'b1;
        tick();
    endtask

    task automatic basic_run(input int gap);
        logic [3:0] syms [5] = '{0, 1, 2, 3, 0};
        logic [8:0] vals [5] = '{9'b0, 9'b10, 9'b110, 9'b111, 9'b0};
        int         lens [5] = '{1, 2, 3, 3, 1};
        do_start(9'd5);
        for (int i = 0; i < 5; i++) begin
            send_code(syms[i], lens[i], vals[i], gap);
            if (i == 2) chk("mid_count", 32'(Sym_count), 3);
        end
        chk("basic_fin", 32'(Fin), 1);
        chk("basic_count", 32'(Sym_count), 5);
        chk("basic_ready", 32'(Bit_ready), 0);
    endtask

    initial begin
        #2;
        check_idle_outputs("por");
        #10 nRst = 1'b1;
        tick();
        check_idle_outputs("init");

        write_code(4'd0, 4'd1, 9'b0);
        write_code(4'd1, 4'd2, 9'b10);
        write_code(4'd2, 4'd3, 9'b110);
        write_code(4'd3, 4'd3, 9'b111);

        basic_run(0);
        basic_run(3);

        // Table write during DECODE must not redefine entry 3 as "1".
        do_start(9'd3);
        write_code(4'd3, 4'd1, 9'b1);
        send_code(4'd1, 2, 9'b10, 0);
        chk("wr_ignored_count", 32'(Sym_count), 1);
        chk("wr_ignored_fin", 32'(Fin), 0);
        send_bit(1'b1);
        pulse_reset();
        check_idle_outputs("post_rst");

        // Empty table: an all-zero stream must error after 9 bits.
        do_start(9'd1);
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b0);
            if (i == 7) chk("empty_err8", 32'(Err), 0);
        end
        chk("empty_err", 32'(Err), 1);
        chk("empty_count", 32'(Sym_count), 0);
        pulse_reset();

        write_code(4'd0, 4'd1, 9'b0);
        write_code(4'd12, 4'd1, 9'b1);
        do_start(9'd2);
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1);
            if (i == 7) chk("err_bit8", 32'(Err), 0);
        end
        chk("err_set", 32'(Err), 1);
        chk("err_ready", 32'(Bit_ready), 0);
        chk("err_count", 32'(Sym_count), 0);
        send_bit(1'b0);
        chk("err_sticky", 32'(Err), 1);
        do_start(9'd1);
        send_code(4'd0, 1, 9'b0, 0);
        chk("after_err_fin", 32'(Fin), 1);

        do_start(9'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_ready", 32'(Bit_ready), 0);
        end
        chk("zero_count", 32'(Sym_count), 0);
        chk("zero_fin", 32'(Fin), 1);
        pulse_reset();

        // Unary table: k ones then a zero, except symbol 9 = nine ones.
        for (int k = 0; k < 9; k++)
            write_code(4'(k), 4'(k + 1), 9'(((1 << k) - 1) << 1));
        write_code(4'd9, 4'd9, 9'h1FF);
        do_start(9'd256);
        for (int s = 0; s < 256; s++) begin
            int k = (s * 7) % 10;
            if (k == 9) send_code(4'd9, 9, 9'h1FF, 0);
            else        send_code(4'(k), k + 1, 9'(((1 << k) - 1) << 1), 0);
            if (s == 254) chk("long_fin_early", 32'(Fin), 0);
        end
        chk("long_count", 32'(Sym_count), 256);
        chk("long_fin", 32'(Fin), 1);
        chk("long_ready", 32'(Bit_ready), 0);

        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder, the receive end of the digit-compression path whose frequency counter produces 9-bit per-digit counts for the encoder. It holds a 10-entry code table for symbols 0–9, accepts one coded bit per handshake, and emits each decoded 4-bit symbol as a one-cycle pulse. It asserts `Fin` after a programmed number of symbols and flags an error on any bit sequence that is not in the table.

## Interface
Parameters:
- `MAX_LEN`, default 9: maximum code length in bits. This is the worst-case depth for 10 symbols.
- `CNT_W`, default 9: width of the symbol counters. Covers 1..256 symbols.

Ports (clock and reset first):
- `Clk_in` input 1: clock, rising edge.
- `nRst` input 1: reset, asynchronous, active-low.
- `Code_wr` input 1: table write strobe. Honoured only in IDLE.
- `Code_sym` input 4: symbol index of the entry to write. Values above 9 are ignored.
- `Code_len` input 4: code length. 0 invalidates the entry; values above `MAX_LEN` are ignored.
- `Code_val` input 9: codeword, right-justified. The first transmitted bit is `Code_val[Code_len-1]`.
- `Start` input 1: one-cycle pulse that starts a decode run. Honoured in IDLE, DONE and ERR.
- `Sym_total` input `CNT_W`: number of symbols to decode. Sampled when `Start` is accepted.
- `Bit_in` input 1: coded bit.
- `Bit_valid` input 1: `Bit_in` is valid this cycle.
- `Bit_ready` output 1: high exactly when the state is DECODE. Combinational from the state register.
- `Sym_out` output 4: decoded symbol.
- `Sym_valid` output 1: one-cycle pulse qualifying `Sym_out`.
- `Sym_count` output `CNT_W`: number of symbols decoded in the current run.
- `Fin` output 1: run complete. Held high until the next `Start` or reset.
- `Err` output 1: invalid code detected. Sticky until the next `Start` or reset.

## Operation
- **States:** IDLE, DECODE, DONE, ERR. Reset enters IDLE.
- **Reset values:** table valid bits = 0, `Sym_out`=0, `Sym_valid`=0, `Sym_count`=0, `Fin`=0, `Err`=0, accumulator `Acc`=0, length `Len`=0.
- **Table write:** `Code_wr` in IDLE writes `{valid = (Code_len!=0), len, val}` to entry `Code_sym`.
  - Writes in any other state are ignored.
  - The table survives across runs and is cleared only by reset.
- **Start transitions:**
  - From IDLE, DONE or ERR: `Start` with `Sym_total`≠0 goes to DECODE. It clears `Sym_count`, `Acc`, `Len`, `Fin` and `Err`, and latches `Sym_total`.
  - `Start` with `Sym_total`=0 goes directly to DONE with `Fin`=1.
  - `Start` while in DECODE is ignored.
- **Bit accept:** a bit is accepted on an edge where `Bit_valid` && `Bit_ready`. Let `n = Len+1` and `A = {Acc[MAX_LEN-2:0], Bit_in}`.
- **Match rule:** entry k matches if valid(k), len(k)==n, and `val(k)[n-1:0] == A[n-1:0]`.
  - If several entries match (non-prefix-free table), the lowest k wins.
- **On a match:**
  - `Sym_out`=k, `Sym_valid`=1, `Sym_count`+1, `Acc`=0, `Len`=0.
  - If the new count equals the latched total: `Fin`=1 and the state goes to DONE.
- **On no match with n<`MAX_LEN`:** `Acc`=A, `Len`=n.
- **On no match with n==`MAX_LEN`:** `Err`=1 and the state goes to ERR. `Sym_count` holds its value.
- **Outside DECODE:** bits are ignored and `Sym_valid` stays 0.
- **Counter width:** `Sym_count` never wraps, because the run ends at `Sym_total` ≤ 2^`CNT_W`−1.

## Timing
- **Latency:** `Sym_valid`/`Sym_out` are registered. They are high during the cycle after the edge that accepted a codeword's last bit.
- **Throughput:** back-to-back symbols are allowed, e.g. 1-bit codes on consecutive bits give consecutive `Sym_valid` pulses.
- **Fin:** rises on the same edge as the final `Sym_valid`. `Bit_ready` falls in that same cycle.
- **Err:** rises on the edge accepting the `MAX_LEN`-th unmatched bit. `Bit_ready` falls with it.
- **Gaps:** `Bit_valid` low leaves `Acc`/`Len` unchanged. Gaps of any length are allowed mid-codeword.
- **Start latency:** `Start` accepted on edge t gives `Bit_ready`=1 from cycle t+1. A bit presented in the same cycle as `Start` is not accepted.
- **Reset mid-operation:** asynchronous reset clears all state and the table immediately. `Bit_ready` drops.

## Test plan
- **Basic decode:** load 0="0"(len1), 1="10"(2), 2="110"(3), 3="111"(3). Apply `Sym_total`=5 and bits 0,1,0,1,1,0,1,1,1,0.
  - Expect `Sym_valid` pulses with 0,1,2,3,0.
  - Expect `Fin`=1 with the 5th pulse, `Sym_count`=5, then `Bit_ready`=0.
- **Gaps:** same stream with `Bit_valid` low for 3 cycles between every bit. Expect identical symbols, each pulse one cycle after its last bit.
- **Error:** table with only 0="0", then `Sym_total`=2 and bits 1 repeated.
  - Expect `Err`=1 after the 9th bit, no `Sym_valid`, state ERR.
  - A following `Start` clears `Err`.
- **Zero count:** `Start` with `Sym_total`=0. Expect `Fin`=1 next cycle, `Bit_ready` never high, `Sym_count`=0.
- **Ignored writes:** attempt a table write during DECODE (ignored, decode unchanged), and a write with `Code_sym`=12 (ignored). Then assert `nRst` mid-run.
  - Expect all outputs 0 and the table empty: a subsequent decode of "0" errors after 9 bits.
- **Full length and 256 symbols:** a 9-bit code decodes correctly, and a run with `Sym_total`=256 gives `Sym_count`=256 at `Fin`.
